// File: rtl/ladybird_bus_arbiter.sv
// Two-master request arbiter for one ladybird memory slave port; responses are routed back through an in-order owner FIFO.
// Define LADYBIRD_ARB_FIXED_PRIO_EN to give port 0 strict priority instead of round-robin.
module ladybird_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   anrst,
  input  logic                                   m0_req,
  output logic                                   m0_gnt,
  input  logic [XLEN-1:0]                        m0_addr,
  input  logic [XLEN-1:0]                        m0_wdata,
  input  logic [XLEN/8-1:0]                      m0_wstrb,
  output logic [XLEN-1:0]                        m0_rdata,
  output logic                                   m0_data_gnt,
  input  logic                                   m1_req,
  output logic                                   m1_gnt,
  input  logic [XLEN-1:0]                        m1_addr,
  input  logic [XLEN-1:0]                        m1_wdata,
  input  logic [XLEN/8-1:0]                      m1_wstrb,
  output logic [XLEN-1:0]                        m1_rdata,
  output logic                                   m1_data_gnt,
  output logic                                   s_req,
  input  logic                                   s_gnt,
  output logic [XLEN-1:0]                        s_addr,
  output logic [XLEN-1:0]                        s_wdata,
  output logic [XLEN/8-1:0]                      s_wstrb,
  input  logic [XLEN-1:0]                        s_data,
  input  logic                                   s_data_gnt,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic          lock_sel_q, lock_sel_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fifo_q [MAX_OUTSTANDING];

  logic sel;
  logic full;
  logic accept;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (m0_req && !m1_req) begin
      sel = 1'b0;
    end else if (!m0_req && m1_req) begin
      sel = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef LADYBIRD_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_q;
`endif
    end
  end

  // Full uses only the registered count, so a same-cycle response never reaches s_req.
  assign full   = (count_q == CW'(MAX_OUTSTANDING));
  assign s_req  = anrst && !full && (sel ? m1_req : m0_req);
  assign accept = s_req && s_gnt;

  assign s_addr  = (s_req && sel) ? m1_addr  : m0_addr;
  assign s_wdata = (s_req && sel) ? m1_wdata : m0_wdata;
  assign s_wstrb = (s_req && sel) ? m1_wstrb : m0_wstrb;

  assign m0_gnt = accept && !sel;
  assign m1_gnt = accept && sel;

  assign pop  = s_data_gnt && (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  assign m0_data_gnt = pop && !head;
  assign m1_data_gnt = pop && head;
  assign m0_rdata    = s_data;
  assign m1_rdata    = s_data;

  assign outstanding = count_q;
  assign err         = err_q;

  always_comb begin
    last_d     = last_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    err_d      = err_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept) begin
      last_d   = sel;
      lock_d   = 1'b0;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (s_req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (s_data_gnt && (count_q == '0)) begin
      err_d = 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Owner IDs need no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Self-checking bench for ladybird_bus_arbiter: queue-based reference model, directed scenarios, then random traffic.
module tb_ladybird_bus_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 2;
`ifdef LADYBIRD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic anrst = 1'b0;
  logic [1:0]            mreq;
  logic [1:0][XLEN-1:0]  maddr;
  logic [1:0][XLEN-1:0]  mwdata;
  logic [1:0][3:0]       mwstrb;
  logic                  s_gnt, s_data_gnt;
  logic [XLEN-1:0]       s_data;

  logic                  m0_gnt, m1_gnt, m0_data_gnt, m1_data_gnt;
  logic [XLEN-1:0]       m0_rdata, m1_rdata;
  logic                  s_req, err;
  logic [XLEN-1:0]       s_addr, s_wdata;
  logic [3:0]            s_wstrb;
  logic [1:0]            outstanding;

  ladybird_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .anrst(anrst),
    .m0_req(mreq[0]), .m0_gnt(m0_gnt), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
    .m0_wstrb(mwstrb[0]), .m0_rdata(m0_rdata), .m0_data_gnt(m0_data_gnt),
    .m1_req(mreq[1]), .m1_gnt(m1_gnt), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
    .m1_wstrb(mwstrb[1]), .m1_rdata(m1_rdata), .m1_data_gnt(m1_data_gnt),
    .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_data(s_data), .s_data_gnt(s_data_gnt), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: owners of in-flight transactions, last winner, port presented but not yet accepted.
  int q[$];
  int mlast     = 1;
  int committed = -1;
  bit merr      = 1'b0;
  int exp_sel;
  bit exp_sreq;
  bit [1:0] acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mlast     = 1;
    committed = -1;
    merr      = 1'b0;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic eval();
    int own;
    #1;
    if (!anrst) model_reset();
    if (committed >= 0)      exp_sel = committed;
    else if (mreq == 2'b01)  exp_sel = 0;
    else if (mreq == 2'b10)  exp_sel = 1;
    else if (mreq == 2'b11)  exp_sel = FIXED ? 0 : 1 - mlast;
    else                     exp_sel = 0;
    exp_sreq = anrst && (q.size() < MAXO) && mreq[exp_sel];
    acc = 2'b00;
    acc[exp_sel] = exp_sreq && s_gnt;
    chk("s_req", s_req, exp_sreq);
    chk("m0_gnt", m0_gnt, acc[0]);
    chk("m1_gnt", m1_gnt, acc[1]);
    if (exp_sreq) begin
      chk("s_addr", s_addr, maddr[exp_sel]);
      chk("s_wdata", s_wdata, mwdata[exp_sel]);
      chk("s_wstrb", s_wstrb, mwstrb[exp_sel]);
    end
    own = (anrst && s_data_gnt && q.size() > 0) ? q[0] : -1;
    chk("m0_data_gnt", m0_data_gnt, own == 0);
    chk("m1_data_gnt", m1_data_gnt, own == 1);
    if (own == 0) chk("m0_rdata", m0_rdata, s_data);
    if (own == 1) chk("m1_rdata", m1_rdata, s_data);
    chk("outstanding", outstanding, q.size());
    chk("err", err, merr);
  endtask

  task automatic adv();
    @(posedge clk);
    if (anrst) begin
      if (s_data_gnt) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1'b1;
      end
      if (exp_sreq && s_gnt) begin
        q.push_back(exp_sel);
        mlast     = exp_sel;
        committed = -1;
      end else if (exp_sreq) begin
        committed = exp_sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    mreq       = 2'b00;
    s_gnt      = 1'b0;
    s_data_gnt = 1'b0;
  endtask

  task automatic do_reset();
    anrst = 1'b0;
    idle();
    eval();
    adv();
    anrst = 1'b1;
  endtask

  initial begin
    idle();
    maddr  = '0;
    mwdata = '0;
    mwstrb = '0;
    s_data = '0;
    @(negedge clk);

    // Single master read
    do_reset();
    mreq = 2'b01; maddr[0] = 32'h100; mwstrb[0] = 4'h0; s_gnt = 1'b1;
    eval(); chk("t1_gnt0", m0_gnt, 1); adv();
    idle(); eval(); adv();
    s_data_gnt = 1'b1; s_data = 32'hDEADBEEF;
    eval();
    chk("t1_dg0", m0_data_gnt, 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_dg1", m1_data_gnt, 0);
    adv(); idle();

    // Contention with next-cycle responses
    do_reset();
    mreq = 2'b11; maddr[0] = 32'h200; maddr[1] = 32'h300; s_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mreq = 2'b00;
      s_data_gnt = (k > 0);
      s_data = 32'(k) + 32'h50;
      eval();
      if (k < 4) begin
        chk("t2_gnt1", m1_gnt, FIXED ? 0 : (k % 2));
        chk("t2_gnt_any", m0_gnt | m1_gnt, 1);
      end
      if (k > 0) chk("t2_route1", m1_data_gnt, FIXED ? 0 : ((k - 1) % 2));
      adv();
    end
    idle();

    // Lock stability
    do_reset();
    mreq = 2'b10; maddr[1] = 32'hA000; maddr[0] = 32'hB000;
    for (int k = 0; k < 5; k++) begin
      s_gnt = (k >= 3);
      if (k == 1) mreq[0] = 1'b1;
      if (k == 4) mreq[1] = 1'b0;
      eval();
      if (k <= 3) chk("t3_saddr", s_addr, 32'hA000);
      if (k < 3)  chk("t3_nogrant", {m0_gnt, m1_gnt}, 0);
      if (k == 3) chk("t3_gnt1", m1_gnt, 1);
      if (k == 4) chk("t3_gnt0", m0_gnt, 1);
      adv();
    end
    idle();

    // Full back-pressure, then push and pop together
    do_reset();
    mreq = 2'b01; s_gnt = 1'b1; maddr[0] = 32'h400;
    eval(); chk("t4_gnt0a", m0_gnt, 1); adv();
    maddr[0] = 32'h404;
    eval(); chk("t4_gnt0b", m0_gnt, 1); adv();
    maddr[0] = 32'h408;
    eval(); chk("t4_out", outstanding, 2); chk("t4_sreq_full", s_req, 0); adv();
    s_data_gnt = 1'b1; s_data = 32'h11;
    eval(); chk("t4_sreq_n", s_req, 0); chk("t4_dg0", m0_data_gnt, 1); adv();
    mreq = 2'b10; maddr[1] = 32'h500; s_data = 32'h22;
    eval();
    chk("t4_sreq_n1", s_req, 1);
    chk("t5_gnt1", m1_gnt, 1);
    chk("t5_dg0", m0_data_gnt, 1);
    chk("t5_dg1", m1_data_gnt, 0);
    adv();
    idle(); s_data_gnt = 1'b1; s_data = 32'h33;
    eval(); chk("t5_out", outstanding, 1); chk("t5_dg1_next", m1_data_gnt, 1); adv();
    idle();

    // Error and asynchronous reset
    do_reset();
    s_data_gnt = 1'b1;
    eval(); chk("t6_nodg", {m0_data_gnt, m1_data_gnt}, 0); chk("t6_err0", err, 0); adv();
    idle();
    eval(); chk("t6_err1", err, 1); adv();
    mreq = 2'b01; s_gnt = 1'b1;
    eval(); adv();
    mreq = 2'b11;
    #2 anrst = 1'b0;
    eval();
    chk("t6_rst_err", err, 0);
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_gnt", {m0_gnt, m1_gnt, s_req}, 0);
    adv();
    anrst = 1'b1;
    eval(); chk("t6_first_gnt0", m0_gnt, 1); adv();
    idle();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mreq[i] || acc[i]) begin
          mreq[i] = ($urandom_range(0, 99) < 55);
          maddr[i]  = $urandom;
          mwdata[i] = $urandom;
          mwstrb[i] = 4'($urandom_range(0, 15));
        end
      end
      s_gnt      = ($urandom_range(0, 99) < 60);
      s_data_gnt = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 199) == 0);
      s_data     = $urandom;
      anrst      = (c % 1000 != 999);
      eval();
      adv();
      anrst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ladybird_bus_arbiter.md
Name: ladybird_bus_arbiter

Overview:
- Shares one memory bus slave port between two ladybird bus masters: port 0 for instruction fetch, port 1 for the MMU data path.
- Arbitrates request-phase handshakes round-robin.
- Records the owner of each accepted transaction in an in-order ID FIFO, so each response is routed back to the master that issued it.
- Sits between ladybird_core and the single external memory / interconnect port.

Parameters:
- XLEN, 32, address and data width.
- MAX_OUTSTANDING, 2, depth of the owner-ID FIFO (maximum accepted but unanswered transactions); power of two, at least 1.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- anrst  input  1  asynchronous active-low reset
- m0_req / m1_req  input  1  master request valid
- m0_gnt / m1_gnt  output  1  request accepted in this cycle
- m0_addr / m1_addr  input  XLEN  request address
- m0_wdata / m1_wdata  input  XLEN  write data
- m0_wstrb / m1_wstrb  input  XLEN/8  byte strobes; all zero means read
- m0_rdata / m1_rdata  output  XLEN  response data
- m0_data_gnt / m1_data_gnt  output  1  response valid, one-cycle pulse
- s_req  output  1  slave request valid
- s_gnt  input  1  slave accepts the request
- s_addr / s_wdata / s_wstrb  output  XLEN / XLEN / XLEN/8  muxed request fields
- s_data  input  XLEN  slave response data
- s_data_gnt  input  1  slave response valid
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  current count of transactions in flight
- err  output  1  sticky: a response arrived with no transaction outstanding

Behaviour:
- Handshakes:
  - A request is accepted when s_req & s_gnt are high in the same cycle.
  - Every accepted request, read or write, receives exactly one s_data_gnt pulse later, in acceptance order.
  - The slave never responds in the cycle of acceptance.
- Masters hold req and all request fields stable until their gnt; the arbiter relies on this.
- Registered state:
  - last (1 b): port of the most recent accept; reset to 1, so port 0 wins first.
  - lock (1 b) and lock_sel (1 b).
  - FIFO storage, wr/rd pointers, count.
  - err.
- sel, combinational:
  - If lock is set, sel = lock_sel.
  - Otherwise, if exactly one port requests, sel = that port.
  - If both request, sel = ~last.
- Full condition: count == MAX_OUTSTANDING.
  - While full, s_req = 0 and both gnt = 0.
  - Full is evaluated from the registered count. A response in the same cycle does not unblock issue until the next cycle, so there is no s_data_gnt -> s_req path.
- Request path when not full:
  - s_req = m_sel_req.
  - s_addr/s_wdata/s_wstrb = fields of sel. When s_req = 0, they carry port 0 fields (don't-care).
  - m_sel_gnt = s_gnt; the other gnt = 0.
- Lock:
  - Set when s_req is high and s_gnt is low: lock <= 1, lock_sel <= sel.
  - Cleared on accept.
  - Guarantees the slave-visible request never changes before acceptance.
- On accept: last <= sel; push sel into the FIFO; count += 1.
- On s_data_gnt:
  - If count > 0: pop the head ID h; m{h}_data_gnt = 1 and m{h}_rdata = s_data in the same cycle (combinational); count -= 1.
  - If count == 0: err <= 1; no master sees a response; FIFO unchanged.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- m*_rdata is s_data when not selected as the response target (don't-care).
- Reset, asynchronous: count = 0, pointers = 0, last = 1, lock = 0, err = 0. All gnt/data_gnt/s_req outputs are 0 while anrst is low. In-flight responses arriving after reset release are flagged by err.
- outstanding = count (registered).

Optional Feature:
- LADYBIRD_ARB_FIXED_PRIO_EN defined:
  - With no lock, both requesting -> sel = 0 always; port 0 has strict priority.
  - last is still updated but ignored by sel.
  - The lock rule is unchanged.
- Not defined: round-robin as above.

Test Plan:
1. Single master, read sequence:
   - Stimulus: m0_req with addr 0x100, s_gnt=1; response 2 cycles later with s_data=0xDEADBEEF.
   - Required: m0_gnt in cycle 0; m0_data_gnt and m0_rdata=0xDEADBEEF exactly with s_data_gnt; m1_data_gnt stays 0.
2. Contention:
   - Stimulus: both request continuously, s_gnt=1, immediate-next-cycle responses, MAX_OUTSTANDING=2.
   - Required: grants alternate 0,1,0,1; responses route to 0,1,0,1.
   - With LADYBIRD_ARB_FIXED_PRIO_EN: all grants to port 0 until m0_req drops.
3. Lock stability:
   - Stimulus: m1_req only, s_gnt=0 for 3 cycles; m0_req rises in cycle 1; s_gnt=1 in cycle 3.
   - Required: s_addr = m1_addr in cycles 0-3; m1_gnt in cycle 3; port 0 granted in cycle 4.
4. Full back-pressure:
   - Stimulus: MAX_OUTSTANDING=2, two accepts, no response.
   - Required: outstanding=2; s_req=0 despite m0_req.
   - Then: response in cycle N gives s_req=0 in cycle N and s_req=1 in cycle N+1.
5. Push and pop in one cycle:
   - Stimulus: outstanding=1; accept and response in the same cycle.
   - Required: outstanding stays 1; the response goes to the older owner.
6. Error and reset:
   - Stimulus: s_data_gnt with outstanding=0.
   - Required: err=1 from the next cycle; no m*_data_gnt.
   - Then: assert anrst mid-transaction. Required: err, outstanding and grants clear to 0 immediately; port 0 wins the first contended grant after release.
